// File: rtl/display_scan_controller.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Shares one external BCD decoder across all digits, with guard blanking and double-buffered loads.
module display_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load_req,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    blank_lz,
    output logic                    load_ack,
    output logic [3:0]              decode_out,
    input  logic [6:0]              decoded_in,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]      SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]      GUARD_END = CNT_W'(GUARD_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF   = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{1'b1}};

    localparam logic [0:0] ST_GUARD = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    logic [0:0]              state;
    logic [CNT_W-1:0]        slot_cnt;
    logic [IDX_W-1:0]        digit_idx;
    logic [4*NUM_DIGITS-1:0] staging;
    logic [4*NUM_DIGITS-1:0] active;
    logic                    pending;
    logic                    restart;
    logic                    blank_slot;

    logic [CNT_W-1:0]        slot_nxt;
    logic [IDX_W-1:0]        idx_nxt;
    logic                    slot_start;
    logic                    frame_wrap;
    logic                    commit;
    logic [4*NUM_DIGITS-1:0] active_nxt;
    logic [3:0]              digit_code;
    logic                    zero_run;
    logic                    blank_nxt;

    // restart marks the first enabled cycle after a dark period; it begins digit 0's slot
    // and is the point where a buffered load gets committed.
    always_comb begin
        slot_nxt   = slot_cnt;
        idx_nxt    = digit_idx;
        slot_start = 1'b0;
        frame_wrap = 1'b0;
        commit     = 1'b0;
        if (!enable) begin
            slot_nxt = '0;
            idx_nxt  = '0;
        end else if (restart) begin
            slot_nxt   = '0;
            idx_nxt    = '0;
            slot_start = 1'b1;
            commit     = pending;
        end else if (slot_cnt == SLOT_LAST) begin
            slot_nxt   = '0;
            slot_start = 1'b1;
            if (digit_idx == IDX_LAST) begin
                idx_nxt    = '0;
                frame_wrap = 1'b1;
                commit     = pending;
            end else begin
                idx_nxt = digit_idx + 1'b1;
            end
        end else begin
            slot_nxt = slot_cnt + 1'b1;
        end
    end

    // Decode and blanking look at the post-commit value so a new frame starts on fresh data.
    always_comb begin
        active_nxt = commit ? staging : active;
        digit_code = active_nxt[{idx_nxt, 2'b00} +: 4];
        zero_run   = 1'b1;
        blank_nxt  = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run && (active_nxt[4*k +: 4] == 4'd0);
            if (idx_nxt == IDX_W'(k)) begin
                blank_nxt = zero_run;
            end
        end
        blank_nxt = blank_nxt && blank_lz;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            staging  <= '0;
            active   <= '0;
            pending  <= 1'b0;
            load_ack <= 1'b0;
        end else begin
            load_ack <= load_req;
            if (commit) begin
                active <= staging;
            end
            if (load_req) begin
                staging <= value_in;
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_GUARD;
            slot_cnt   <= '0;
            digit_idx  <= '0;
            restart    <= 1'b0;
            blank_slot <= 1'b0;
            decode_out <= 4'd0;
            frame_done <= 1'b0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
        end else begin
            slot_cnt   <= slot_nxt;
            digit_idx  <= idx_nxt;
            restart    <= !enable;
            frame_done <= frame_wrap;
            if (slot_start) begin
                decode_out <= digit_code;
                blank_slot <= blank_nxt;
            end
            if (!enable) begin
                state <= ST_GUARD;
                an    <= AN_OFF;
                seg   <= SEG_OFF;
            end else if (state == ST_GUARD && slot_nxt == GUARD_END) begin
                // decoded_in reflects decode_out loaded at slot start; capture it once and hold.
                state <= ST_DRIVE;
                an    <= ~(NUM_DIGITS'(1) << idx_nxt);
                seg   <= blank_slot ? SEG_OFF : decoded_in;
            end else if (state == ST_DRIVE && slot_start) begin
                state <= ST_GUARD;
                an    <= AN_OFF;
                seg   <= SEG_OFF;
            end
        end
    end

endmodule
